// File: rtl/rv32_ifetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch responder.
package rv32_ifetch_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFS_IDLE = 2'd0,
    IFS_REQ  = 2'd1,
    IFS_WAIT = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/rv32_ifetch_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch unit and imem.
interface rv32_ifetch_if
  import rv32_ifetch_pkg::*;
#(
  parameter int AW = 16
) ();

  logic            req;
  logic [AW-1:0]   addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/rv32_ifetch.sv
// Instruction-fetch responder: fetches the word at pc from a variable-latency
// imem and delivers it on code_bus, stalling the PC unit via busy meanwhile.
//
// state | meaning
// IDLE  | parked (reset or halted); no request
// REQ   | presenting pc to imem, or delivering a fault for out-of-range pc
// WAIT  | granted; waiting for the single rvalid of this transaction
module rv32_ifetch
  import rv32_ifetch_pkg::*;
#(
  parameter int          IMEM_AW = 16,
  parameter logic [31:0] NOP     = RV32_NOP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc,
  input  logic          flush,
  input  logic          halt,
  output logic [31:0]   code_bus,
  output logic          busy,
  output logic          fetch_fault,
  output logic [31:0]   fetch_cnt,
  rv32_ifetch_if.master imem
);

  localparam logic [1:0] S_IDLE = IFS_IDLE;
  localparam logic [1:0] S_REQ  = IFS_REQ;
  localparam logic [1:0] S_WAIT = IFS_WAIT;

  logic [1:0]  state_q, state_d;
  logic [31:0] tag_q, tag_d;
  logic [31:0] code_q, code_d;
  logic [31:0] cnt_q, cnt_d;

  logic in_range;
  logic req;
  logic deliver;
  logic fault;

  assign in_range = (pc[31:IMEM_AW] == '0);

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    deliver  = 1'b0;
    fault    = 1'b0;
    code_bus = code_q;

    case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_REQ;
      end
      S_REQ: begin
        req = !halt && in_range;
        if (req && imem.gnt) begin
          tag_d   = pc;
          state_d = S_WAIT;
        end else if (halt) begin
          state_d = S_IDLE;
        end else if (!in_range) begin
          // Unreachable address: complete the fetch immediately with a NOP.
          deliver  = 1'b1;
          fault    = 1'b1;
          code_bus = NOP;
          code_d   = NOP;
        end
      end
      S_WAIT: begin
        // A response for a stale pc (redirected or flushed) is dropped and refetched.
        if (imem.rvalid) begin
          if ((tag_q == pc) && !flush) begin
            deliver  = 1'b1;
            code_bus = imem.rdata;
            code_d   = imem.rdata;
          end
          state_d = halt ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) cnt_d = cnt_q + 32'd1;
    if (flush)   code_d = NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      code_q  <= NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = !deliver;
  assign fetch_fault = fault;
  assign fetch_cnt   = cnt_q;
  assign imem.req    = req;
  assign imem.addr   = pc[IMEM_AW-1:0];

endmodule

// File: tb/tb_rv32_ifetch.sv
// Bench for rv32_ifetch: directed scenarios plus a randomized run against a
// transaction-level model of the fetch protocol.
module tb_rv32_ifetch;
  import rv32_ifetch_pkg::*;

  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] code_bus;
  logic        busy;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  rv32_ifetch_if #(.AW(AW)) imem_if ();

  rv32_ifetch #(.IMEM_AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .flush       (flush),
    .halt        (halt),
    .code_bus    (code_bus),
    .busy        (busy),
    .fetch_fault (fetch_fault),
    .fetch_cnt   (fetch_cnt),
    .imem        (imem_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of the fetch unit: parked/armed, one outstanding fetch, held code, count.
  bit          m_armed;
  bit          m_out;
  logic [31:0] m_tag;
  logic [31:0] m_code;
  logic [31:0] m_cnt;

  // Instruction memory: at most one pending response with a random latency.
  bit          mem_pend = 0;
  int          mem_cnt  = 0;
  logic [AW-1:0] mem_addr = '0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100;

  bit          o_deliv, o_req, o_fault;
  logic [31:0] o_code;
  logic [31:0] last_gaddr;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, clock.
  task automatic step();
    logic        rv, in_rng, e_req, e_del, e_flt, g;
    logic [31:0] e_code;
    logic [AW-1:0] gaddr;
    rv = mem_pend && (mem_cnt == 0);
    imem_if.rvalid = rv;
    imem_if.rdata  = rv ? mem_word(mem_addr) : $urandom();
    imem_if.gnt    = ($urandom_range(99) < gnt_pct);
    #2;
    in_rng = (pc[31:AW] == '0);
    e_req  = !m_out && m_armed && !halt && in_rng;
    e_del  = 1'b0;
    e_flt  = 1'b0;
    e_code = m_code;
    if (m_out && rv) begin
      if ((m_tag == pc) && !flush) begin
        e_del  = 1'b1;
        e_code = imem_if.rdata;
      end
    end else if (!m_out && m_armed && !halt && !in_rng) begin
      e_del  = 1'b1;
      e_flt  = 1'b1;
      e_code = RV32_NOP;
    end
    check_val("imem_req",    32'(imem_if.req),  32'(e_req));
    check_val("imem_addr",   32'(imem_if.addr), 32'(pc[AW-1:0]));
    check_val("busy",        32'(busy),         32'(!e_del));
    check_val("code_bus",    code_bus,          e_code);
    check_val("fetch_fault", 32'(fetch_fault),  32'(e_flt));
    check_val("fetch_cnt",   fetch_cnt,         m_cnt);
    o_deliv = !busy;
    o_req   = imem_if.req;
    o_fault = fetch_fault;
    o_code  = code_bus;
    g       = imem_if.req && imem_if.gnt;
    gaddr   = imem_if.addr;

    if (m_out) begin
      if (rv) begin
        m_out   = 0;
        m_armed = !halt;
      end
    end else if (!m_armed) begin
      m_armed = !halt;
    end else if (e_req && imem_if.gnt) begin
      m_out = 1;
      m_tag = pc;
    end else if (halt) begin
      m_armed = 0;
    end
    if (e_del) begin
      m_cnt  = m_cnt + 1;
      m_code = e_code;
    end
    if (flush) m_code = RV32_NOP;

    @(posedge clk);
    #1;
    if (rv) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (g) begin
      mem_pend   = 1;
      mem_addr   = gaddr;
      last_gaddr = 32'(gaddr);
      mem_cnt    = int'($urandom_range(lat_max, lat_min)) - 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_if.gnt = 1'b0;
    imem_if.rvalid = 1'b0;
    imem_if.rdata = '0;
    m_armed = 0; m_out = 0; m_tag = '0; m_code = RV32_NOP; m_cnt = '0;
    #2;
    check_val("rst_code_bus", code_bus, RV32_NOP);
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_fault", 32'(fetch_fault), 32'd0);
    check_val("rst_cnt", fetch_cnt, 32'd0);
    check_val("rst_req", 32'(imem_if.req), 32'd0);
    check_val("rst_addr", 32'(imem_if.addr), 32'(pc[AW-1:0]));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, first, last, nb, nrd;
    #1;

    // Zero-wait memory, sequential pc 0..7.
    pc = '0;
    do_reset();
    mem_pend = 0; lat_min = 1; lat_max = 1; gnt_pct = 100;
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 40 && n < 8; i++) begin
      step();
      if (o_deliv) begin
        check_val("t2_code", o_code, 32'h1000_0000 + pc);
        if (n == 0) first = i;
        last = i;
        n++;
        pc = pc + 1;
      end
    end
    check_val("t2_deliveries", 32'(n), 32'd8);
    check_val("t2_first_cycle", 32'(first), 32'd2);
    check_val("t2_span", 32'(last - first), 32'd14);
    check_val("t2_fetch_cnt", fetch_cnt, 32'd8);

    // 3-cycle latency from reset.
    pc = 32'd5;
    do_reset();
    mem_pend = 0; lat_min = 3; lat_max = 3;
    nb = 0; o_deliv = 0;
    while (!o_deliv && nb < 20) begin
      step();
      if (!o_deliv) nb++;
    end
    check_val("t3_busy_cycles", 32'(nb), 32'd4);
    check_val("t3_code", o_code, 32'h1000_0005);

    // Redirect while waiting: stale response dropped, new address fetched.
    pc = 32'd5;
    do_reset();
    mem_pend = 0;
    step(); step();
    pc = 32'd20;
    nb = 0; o_deliv = 0;
    while (!o_deliv && nb < 20) begin
      step();
      nb++;
    end
    check_val("t4_code", o_code, 32'h1000_0014);
    check_val("t4_regrant_addr", last_gaddr, 32'd20);
    check_val("t4_fetch_cnt", fetch_cnt, 32'd1);

    // Halt during WAIT: response still accepted, then parked.
    pc = 32'd3;
    do_reset();
    mem_pend = 0;
    step(); step();
    halt = 1'b1;
    step(); step(); step();
    check_val("t5_accept", 32'(o_deliv), 32'd1);
    step();
    check_val("t5_idle_req", 32'(o_req), 32'd0);
    halt = 1'b0;
    step();
    check_val("t5_req_1", 32'(o_req), 32'd0);
    step();
    check_val("t5_req_2", 32'(o_req), 32'd1);

    // Out-of-range pc: immediate fault delivery.
    pc = 32'h0001_0000;
    do_reset();
    mem_pend = 0;
    step();
    step();
    check_val("t6_fault", 32'(o_fault), 32'd1);
    check_val("t6_deliver", 32'(o_deliv), 32'd1);
    check_val("t6_code", o_code, RV32_NOP);
    check_val("t6_req", 32'(o_req), 32'd0);
    check_val("t6_fetch_cnt", fetch_cnt, 32'd1);

    // Reset mid-WAIT, stale rvalid shortly after release.
    pc = 32'd2;
    do_reset();
    mem_pend = 0; lat_min = 4; lat_max = 4;
    step(); step(); step();
    do_reset();
    mem_pend = 1; mem_cnt = 1; gnt_pct = 0;
    step();
    step();
    check_val("t7_stale_ignored", 32'(o_deliv), 32'd0);
    step();
    check_val("t7_fetch_cnt", fetch_cnt, 32'd0);
    check_val("t7_code", code_bus, RV32_NOP);

    // Randomized traffic.
    pc = '0;
    do_reset();
    mem_pend = 0; lat_min = 1; lat_max = 4; gnt_pct = 70;
    nrd = 0; o_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      if (o_deliv) pc = pc + 1;
      halt  = ($urandom_range(99) < 10);
      flush = ($urandom_range(99) < 5);
      if (flush || $urandom_range(99) < 3)
        pc = ($urandom_range(99) < 10) ? ($urandom() | 32'h0001_0000)
                                       : 32'($urandom_range(255));
      step();
      if (o_deliv) nrd++;
    end
    halt = 1'b0; flush = 1'b0;
    check_val("rand_activity", 32'(nrd > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_ifetch.md
# rv32_ifetch

Instruction-fetch responder for the 5-stage core: serves the word address driven by the PC unit (`pc`), fetches the instruction from a variable-latency instruction memory over a req/gnt/rvalid handshake, and returns it on `code_bus`. `busy` stalls the PC unit until the instruction is delivered. The block sits between the PC unit and the instruction memory, and also feeds the IF/ID register.

## Interface
- `IMEM_AW`, default 16: instruction memory word-address width.
- `NOP`, default 32'h0000_0013: `addi x0,x0,0`, the value driven when no valid instruction exists.
- `clk`  in  1  clock, single domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  in  32  word address of the next instruction (PC increments by 1 per instruction).
- `flush`  in  1  PC-unit redirect/reset indication; squashes the IF/ID instruction.
- `halt`  in  1  PC unit disabled; no new fetches are issued.
- `code_bus`  out  32  instruction at `pc`. Valid in the delivery cycle; otherwise the held value.
- `busy`  out  1  PC must not advance. Low only in a delivery cycle.
- `fetch_fault`  out  1  `pc[31:IMEM_AW]` is nonzero in the current delivery.
- `fetch_cnt`  out  32  delivered-instruction count; wraps.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  IMEM_AW  request word address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid; exactly one per grant, in order, at least 1 cycle after the grant.
- `imem_rdata`  in  32  read data.

## Operation
- FSM states IDLE, REQ, WAIT. Reset → IDLE.
- IDLE: `imem_req`=0. If `!halt`, go to REQ next cycle.
- REQ:
  - `imem_req` = `!halt & in_range`, where `in_range` = (`pc[31:IMEM_AW]`==0). `imem_addr` = `pc[IMEM_AW-1:0]`.
  - `imem_gnt & imem_req`: latch `tag_q` <= `pc`, go to WAIT.
  - `halt` with no grant: go to IDLE.
  - `!in_range & !halt`: fault delivery this cycle. `code_bus`=NOP, `fetch_fault`=1, `busy`=0, stay in REQ.
- WAIT: `imem_req`=0. `imem_gnt` is ignored.
  - On `imem_rvalid`: match = (`tag_q`==`pc`) & `!flush`.
  - If match: delivery. `code_bus`=`imem_rdata` (combinational), `busy`=0, `code_q` <= `imem_rdata`, `fetch_cnt` += 1.
  - If no match: the response is dropped and `busy` stays 1.
  - Next state is REQ if `!halt`, else IDLE.
  - `halt` during WAIT does not abandon the transaction; the block waits for `imem_rvalid` regardless.
- `imem_rvalid` outside WAIT (e.g. after a mid-transaction reset) is ignored. The instruction memory shares `rst_n`.
- `flush`=1 in any cycle: `code_q` <= NOP (takes priority over a same-cycle delivery write).
- Outside delivery cycles, `code_bus`=`code_q` and `fetch_fault`=0.
- Fault deliveries increment `fetch_cnt` and load `code_q` <= NOP.

## Timing
- Reset values:
  - state IDLE, `code_q`/`code_bus`=NOP
  - `busy`=1, `fetch_fault`=0, `fetch_cnt`=0
  - `imem_req`=0, `imem_addr`=0 (`pc` is 0 at reset), `tag_q`=0
- Latency: the earliest delivery is 1 cycle after the grant. With zero-wait memory, throughput is 1 instruction per 2 cycles: REQ+gnt, then WAIT+rvalid.
- First fetch after reset: IDLE (1 cycle) → REQ.
- `busy` is combinational from state, `imem_rvalid`, the tag compare and `flush`. `code_bus` is combinational in the delivery cycle.
- The PC advances on the edge that ends the delivery cycle. The next REQ therefore sees the new `pc`.
- Simultaneous `flush` & `imem_rvalid` in WAIT: the response is dropped, then re-requested.
- Simultaneous `halt` & `imem_gnt` in REQ: no request is issued, because `imem_req` is gated by `halt`.

## Structure
- `rv32_ifetch_pkg`: `ifetch_state_t` enum (IDLE, REQ, WAIT) and `RV32_NOP` constant.
- Single module, no sub-module. The FSM, tag register, output mux and counter are all local.

## Test plan
- Zero-wait memory returning `mem[a]`=32'h1000_0000+a, `pc` stepping 0..7 on each `busy`=0 → eight deliveries 2 cycles apart, `code_bus` matching, `fetch_cnt`=8.
- Memory with 3-cycle rvalid latency, `pc`=5 → `busy`=1 for 4 cycles, then 1 delivery cycle with `code_bus`=32'h1000_0005.
- `pc` changed 5→20 while in WAIT for address 5 → response dropped, `busy` held, re-request `imem_addr`=20, delivery of 32'h1000_0014.
- `halt`=1 during WAIT → the in-flight rvalid is accepted, then IDLE with `imem_req`=0. `halt`=0 → request 2 cycles later.
- `pc`=32'h0001_0000 with `IMEM_AW`=16 → no `imem_req`, `code_bus`=NOP, `fetch_fault`=1, `busy`=0 the same cycle.
- `rst_n` low mid-WAIT, then a stale rvalid 1 cycle after release → ignored, outputs at reset values, `fetch_cnt`=0.
